// File: rtl/cpu_io_unit.sv
// rtl/cpu_io_unit.sv - byte-wide CPU I/O front end
// Input FIFO feeding the CPU's input instruction, output byte handshake with inter-word gap, interrupt flags.
module cpu_io_unit #(
   parameter int DEPTH  = 4,
   parameter int TX_GAP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] cpu_inp,
   input  logic        cpu_rd,
   output logic        FI,
   input  logic [31:0] cpu_out_data,
   input  logic        cpu_wr,
   output logic        FO,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        ion,
   input  logic        iof,
   input  logic        irq_ack,
   output logic        INT,
   output logic        irq,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP + 1) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(TX_GAP);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push, pop;
   state_t        state, state_nxt;
   logic [GW-1:0] gap_cnt;
   logic          tx_pend;
   logic          wr_accept, handshake;
   logic          unused_hi;

   assign unused_hi = ^cpu_out_data[31:8];

   assign FI       = (count != '0);
   assign in_ready = (count != FULL_CNT);
   assign push     = in_valid & in_ready;
   assign pop      = cpu_rd & FI;
   assign cpu_inp  = FI ? {24'h0, mem[rd_ptr]} : 32'h0;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      FO        = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            FO = 1'b1;
            if (cpu_wr)
               state_nxt = SEND;
         end
         SEND: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = (TX_GAP == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_cnt == GAP_ONE)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_accept = cpu_wr & (state == IDLE);
   assign handshake = (state == SEND) & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= 8'h00;
         gap_cnt  <= '0;
         tx_pend  <= 1'b0;
         INT      <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (wr_accept)
            out_data <= cpu_out_data[7:0];
         if (handshake)
            gap_cnt <= GAP_LOAD;
         else if (state == GAP)
            gap_cnt <= gap_cnt - GAP_ONE;
         // A completed send outranks a simultaneous acknowledge.
         if (handshake)
            tx_pend <= 1'b1;
         else if (irq_ack || wr_accept)
            tx_pend <= 1'b0;
         if (iof)
            INT <= 1'b0;
         else if (ion)
            INT <= 1'b1;
         if ((cpu_rd && !FI) || (cpu_wr && state != IDLE))
            err <= 1'b1;
      end
   end

   assign irq = INT & (FI | tx_pend);

endmodule

// File: tb/tb_cpu_io_unit.sv
// tb/tb_cpu_io_unit.sv - self-checking bench for cpu_io_unit
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_cpu_io_unit;

   localparam int DEPTH  = 4;
   localparam int TX_GAP = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] cpu_inp;
   logic        cpu_rd = 1'b0;
   logic        FI;
   logic [31:0] cpu_out_data = 32'h0;
   logic        cpu_wr = 1'b0;
   logic        FO;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        ion = 1'b0;
   logic        iof = 1'b0;
   logic        irq_ack = 1'b0;
   logic        INT;
   logic        irq;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   cpu_io_unit #(.DEPTH(DEPTH), .TX_GAP(TX_GAP)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cpu_inp(cpu_inp), .cpu_rd(cpu_rd), .FI(FI), .cpu_out_data(cpu_out_data), .cpu_wr(cpu_wr),
      .FO(FO), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ion(ion),
      .iof(iof), .irq_ack(irq_ack), .INT(INT), .irq(irq), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, output path as "byte waiting" plus the edge number FO returns.
   logic [7:0] q[$];
   bit         m_valid = 0;
   logic [7:0] m_byte = 8'h00;
   int         m_fo_edge = 0;
   bit         m_pend = 0;
   bit         m_int = 0;
   bit         m_err = 0;
   int         cyc = 0;
   bit         fo_pre, hs, do_push, do_pop, was_empty;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_valid = 0; m_byte = 8'h00; m_fo_edge = 0;
         m_pend = 0; m_int = 0; m_err = 0;
      end else begin
         fo_pre    = !m_valid && (cyc >= m_fo_edge);
         hs        = m_valid && out_ready;
         was_empty = (q.size() == 0);
         do_pop    = cpu_rd && !was_empty;
         do_push   = in_valid && (q.size() < DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(in_data);
         if (cpu_rd && was_empty) m_err = 1;
         if (cpu_wr && !fo_pre) m_err = 1;
         if (cpu_wr && fo_pre) begin
            m_valid = 1;
            m_byte  = cpu_out_data[7:0];
         end
         if (hs) begin
            m_valid   = 0;
            m_fo_edge = cyc + 1 + TX_GAP;
         end
         if (hs) m_pend = 1;
         else if (irq_ack || (cpu_wr && fo_pre)) m_pend = 0;
         if (iof) m_int = 0;
         else if (ion) m_int = 1;
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic [31:0] e_inp;
      bit e_fi;
      e_fi  = (q.size() != 0);
      e_inp = e_fi ? {24'h0, q[0]} : 32'h0;
      check("in_ready", {31'h0, in_ready}, {31'h0, q.size() < DEPTH});
      check("FI", {31'h0, FI}, {31'h0, e_fi});
      check("cpu_inp", cpu_inp, e_inp);
      check("FO", {31'h0, FO}, {31'h0, !m_valid && (cyc >= m_fo_edge)});
      check("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      check("out_data", {24'h0, out_data}, {24'h0, m_byte});
      check("INT", {31'h0, INT}, {31'h0, m_int});
      check("irq", {31'h0, irq}, {31'h0, m_int && (e_fi || m_pend)});
      check("err", {31'h0, err}, {31'h0, m_err});
   end

   task automatic push(input logic [7:0] b);
      in_valid = 1'b1; in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop();
      cpu_rd = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_wr(input logic [31:0] d);
      cpu_wr = 1'b1; cpu_out_data = d;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_seq [4];
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_FO", {31'h0, FO}, 32'h1);
      check("rst_cpu_inp", cpu_inp, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);

      // Fill to full, drain in order.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      check("full_in_ready", {31'h0, in_ready}, 32'h0);
      exp_seq = '{8'h22, 8'h33, 8'h44, 8'h00};
      check("head0", cpu_inp, 32'h11);
      for (int i = 0; i < 4; i++) begin
         pop();
         check("drain_head", cpu_inp, {24'h0, exp_seq[i]});
      end
      check("drain_FI", {31'h0, FI}, 32'h0);
      check("drain_err", {31'h0, err}, 32'h0);

      // Pointer wrap-around.
      push(8'hA1); push(8'hA2); push(8'hA3);
      pop(); pop();
      push(8'hB1); push(8'hB2); push(8'hB3);
      check("wrap_full", {31'h0, in_ready}, 32'h0);
      check("wrap_head", cpu_inp, 32'hA3);
      exp_seq = '{8'hB1, 8'hB2, 8'hB3, 8'h00};
      for (int i = 0; i < 4; i++) begin
         pop();
         check("wrap_order", cpu_inp, {24'h0, exp_seq[i]});
      end

      // Simultaneous push and pop at count 2.
      push(8'hC1); push(8'hC2);
      in_valid = 1'b1; in_data = 8'hC3; cpu_rd = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; cpu_rd = 1'b0;
      check("pp_head", cpu_inp, 32'hC2);
      pop();
      check("pp_second", cpu_inp, 32'hC3);
      pop();
      check("pp_empty", {31'h0, FI}, 32'h0);

      // Output with held-off consumer, then gap.
      pulse_wr(32'hDEADBEEF);
      check("tx_valid", {31'h0, out_valid}, 32'h1);
      check("tx_FO", {31'h0, FO}, 32'h0);
      check("tx_data", {24'h0, out_data}, 32'hEF);
      idle(3);
      check("tx_hold_valid", {31'h0, out_valid}, 32'h1);
      check("tx_hold_data", {24'h0, out_data}, 32'hEF);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_valid", {31'h0, out_valid}, 32'h0);
      check("hs_FO", {31'h0, FO}, 32'h0);
      check("hs_err", {31'h0, err}, 32'h0);
      pulse_wr(32'h12345678);
      check("gap_FO", {31'h0, FO}, 32'h0);
      check("gap_wr_data", {24'h0, out_data}, 32'hEF);
      check("gap_wr_err", {31'h0, err}, 32'h1);
      @(negedge clk);
      check("gap_end_FO", {31'h0, FO}, 32'h1);

      // Interrupts.
      irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
      ion = 1'b1; @(negedge clk); ion = 1'b0;
      check("int_on", {31'h0, INT}, 32'h1);
      check("irq_idle", {31'h0, irq}, 32'h0);
      push(8'h99);
      check("irq_fi", {31'h0, irq}, 32'h1);
      pop();
      check("irq_pop", {31'h0, irq}, 32'h0);
      cpu_wr = 1'b1; cpu_out_data = 32'h0000005A; out_ready = 1'b1;
      @(negedge clk);
      cpu_wr = 1'b0;
      check("irq_send", {31'h0, irq}, 32'h0);
      @(negedge clk);
      out_ready = 1'b0;
      check("irq_txdone", {31'h0, irq}, 32'h1);
      idle(2);
      irq_ack = 1'b1; @(negedge clk); irq_ack = 1'b0;
      check("irq_ack", {31'h0, irq}, 32'h0);
      ion = 1'b1; iof = 1'b1; @(negedge clk); ion = 1'b0; iof = 1'b0;
      check("int_iof_wins", {31'h0, INT}, 32'h0);

      // Asynchronous reset in the middle of a send.
      ion = 1'b1; @(negedge clk); ion = 1'b0;
      push(8'h61); push(8'h62);
      pulse_wr(32'h77);
      idle(1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", {31'h0, out_valid}, 32'h0);
      check("arst_FO", {31'h0, FO}, 32'h1);
      check("arst_FI", {31'h0, FI}, 32'h0);
      check("arst_in_ready", {31'h0, in_ready}, 32'h1);
      check("arst_cpu_inp", cpu_inp, 32'h0);
      check("arst_out_data", {24'h0, out_data}, 32'h0);
      check("arst_INT", {31'h0, INT}, 32'h0);
      check("arst_irq", {31'h0, irq}, 32'h0);
      check("arst_err", {31'h0, err}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Empty pop sets a sticky error.
      idle(1);
      pop();
      check("empty_pop_err", {31'h0, err}, 32'h1);
      idle(3);
      check("err_sticky", {31'h0, err}, 32'h1);
      check("empty_pop_fi", {31'h0, FI}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
